// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
//   Request/response bundle between the CPU control FSM (master) and the
//   memory responder (slave).
//
//   mem_read         master -> slave  read request, held until mem_resp
//   mem_write        master -> slave  write request, held until mem_resp
//   mem_byte_enable  master -> slave  write byte mask, bit i -> byte i
//   mem_address      master -> slave  byte address, [1:0] ignored
//   mem_wdata        master -> slave  write data
//   mem_rdata        slave -> master  read data, held until next read completes
//   mem_resp         slave -> master  one-cycle completion pulse
// -----------------------------------------------------------------------------
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_address,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multicycle RV32I datapath. Accepts one
//   word-wide read or byte-masked write at a time, holds it for LATENCY wait
//   cycles and completes it with a single-cycle mem_resp pulse. Word storage
//   is internal, so the block doubles as main memory for top-level sims and
//   FPGA bring-up.
//
// Parameters
//   LATENCY  wait cycles between request acceptance and mem_resp (0..255)
//   DEPTH    number of 32-bit words stored; power of two, >= 2
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of mem_responder_if (request in, rdata/resp out)
//   err    out  sticky: read and write were both high when a request was
//               accepted (the write was performed)
//
// Timing
//   Request seen at accept edge k -> mem_resp high in the cycle following
//   edge k+LATENCY. After RESP there is one DONE turnaround cycle, so
//   responses are at least LATENCY+3 cycles apart.
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus,
  output logic            err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [7:0]  LAT8  = LATENCY[7:0];

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       wait_cnt;

  // Request captured on the accept edge; bus changes after that are ignored.
  logic             req_is_write;
  logic [IDX_W-1:0] req_idx;
  logic [3:0]       req_be;
  logic [31:0]      req_wdata;

  logic [31:0]      mem [DEPTH];

  logic             req_any;
  logic [IDX_W-1:0] in_idx;

  // Address bits outside the word index are dropped, so addresses wrap
  // modulo DEPTH*4. The name keeps them out of unused-signal reports.
  logic             unused_addr_bits;

  assign req_any          = bus.mem_read | bus.mem_write;
  assign in_idx           = bus.mem_address[2 +: IDX_W];
  assign unused_addr_bits = ^{bus.mem_address[31:2+IDX_W], bus.mem_address[1:0]};

  // ---------------------------------------------------------------------------
  // Control FSM with registered mem_resp / mem_rdata / err.
  // Read data is fetched on the edge that enters RESP so it is valid for the
  // whole mem_resp cycle. With LATENCY==0 that edge is the accept edge itself,
  // so the live bus index is used there instead of the (not yet) latched one.
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses <= so all of them see the pre-edge values
  // of each other; a blocking = would make ordering inside the block matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      bus.mem_resp  <= 1'b0;
      bus.mem_rdata <= '0;
      err           <= 1'b0;
      req_is_write  <= 1'b0;
      req_idx       <= '0;
      req_be        <= '0;
      req_wdata     <= '0;
    end else begin
      bus.mem_resp <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req_any) begin
            // Write wins when both are high; the conflict is only flagged.
            req_is_write <= bus.mem_write;
            req_idx      <= in_idx;
            req_be       <= bus.mem_byte_enable;
            req_wdata    <= bus.mem_wdata;
            wait_cnt     <= LAT8;
            if (bus.mem_read && bus.mem_write) begin
              err <= 1'b1;
            end
            if (LAT8 == 8'd0) begin
              state        <= RESP;
              bus.mem_resp <= 1'b1;
              if (!bus.mem_write) begin
                bus.mem_rdata <= mem[in_idx];
              end
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!req_any) begin
            // Initiator withdrew: drop the request without any side effect.
            state    <= IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
            if (wait_cnt == 8'd1) begin
              state        <= RESP;
              bus.mem_resp <= 1'b1;
              if (!req_is_write) begin
                bus.mem_rdata <= mem[req_idx];
              end
            end
          end
        end

        RESP: begin
          state <= DONE;
        end

        DONE: begin
          // Turnaround: lets the initiator drop its request after mem_resp.
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. A write commits on the edge that ends the RESP cycle. An async
  // reset pulls state out of RESP before that edge, so an interrupted write
  // never lands.
  // ---------------------------------------------------------------------------
  // NOTE: the array deliberately has no reset; clearing DEPTH words would
  // defeat RAM inference and its contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (state == RESP && req_is_write) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) begin
          mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Two responders: dut_a with LATENCY=2 and dut_b with LATENCY=0, both with
//   DEPTH=1024. A word-array model tracks memory, last read data and the
//   sticky error flag. Directed cases cover reset, masks, abort, conflict
//   and wrap. A randomized section then mixes reads and masked writes.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int DEPTH = 1024;

  logic clk;
  logic rst_n;

  mem_responder_if ifa ();
  mem_responder_if ifb ();
  logic err_a;
  logic err_b;

  mem_responder #(.LATENCY(LAT_A), .DEPTH(DEPTH)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave),
    .err   (err_a)
  );

  mem_responder #(.LATENCY(LAT_B), .DEPTH(DEPTH)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave),
    .err   (err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model, one entry per DUT.
  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] exp_rdata [2];
  logic        exp_err   [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input bit rd, input bit wr, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (d == 0) begin
      ifa.mem_read = rd; ifa.mem_write = wr; ifa.mem_byte_enable = be;
      ifa.mem_address = addr; ifa.mem_wdata = wd;
    end else begin
      ifb.mem_read = rd; ifb.mem_write = wr; ifb.mem_byte_enable = be;
      ifb.mem_address = addr; ifb.mem_wdata = wd;
    end
  endtask

  function automatic logic get_resp(input int d);
    return (d == 0) ? ifa.mem_resp : ifb.mem_resp;
  endfunction

  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? ifa.mem_rdata : ifb.mem_rdata;
  endfunction

  function automatic logic get_err(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction

  // Word index: address divided by 4, modulo DEPTH.
  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with the request held until mem_resp. While
  // waiting, address/data/mask are scrambled to show they are latched.
  // Returns once the responder is back in its idle state.
  task automatic do_op(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input string tag);
    int n;
    int lat;
    int w;
    lat = (d == 0) ? LAT_A : LAT_B;
    w   = word_of(addr);
    drive(d, rd, wr, be, addr, wd);
    n = 0;
    do begin
      tick();
      n++;
      if (!get_resp(d)) drive(d, rd, wr, 4'($urandom), $urandom, $urandom);
    end while (!get_resp(d) && n < 300);
    check({tag, "_lat"}, n, lat + 1);

    if (rd && wr) exp_err[d] = 1'b1;
    if (rd && !wr) exp_rdata[d] = model_mem[d][w];
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[d][w][8*b +: 8] = wd[8*b +: 8];
    end
    check({tag, "_rdata"}, get_rdata(d), exp_rdata[d]);
    check({tag, "_err"}, {31'd0, get_err(d)}, {31'd0, exp_err[d]});

    drive(d, 1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
    tick();
    check({tag, "_pulse"}, {31'd0, get_resp(d)}, 32'd0);
    tick();
  endtask

  logic [31:0] rand_addr [16];
  logic [31:0] fetch_addr [8];
  int          n;

  initial begin
    total = 0;
    bad   = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err[0]   = 1'b0; exp_err[1] = 1'b0;

    rst_n = 1'b0;
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    check("rst_resp_a", {31'd0, ifa.mem_resp}, 32'd0);
    check("rst_rdata_a", ifa.mem_rdata, 32'h0);
    check("rst_err_a", {31'd0, err_a}, 32'd0);
    check("rst_resp_b", {31'd0, ifb.mem_resp}, 32'd0);
    check("rst_rdata_b", ifb.mem_rdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // ---- reset in the middle of a write's wait --------------------------
    do_op(0, 1, 0, 32'h10, 32'h0, 4'h0, "pre_wr_rd_skip_dummy") ; // harmless read slot
    // The dummy read above hit an unwritten word; re-seed the model with it.
    model_mem[0][word_of(32'h10)] = ifa.mem_rdata;
    do_op(0, 0, 1, 32'h10, 32'h0BADF00D, 4'hF, "seed10");
    do_op(0, 1, 0, 32'h10, 32'h0, 4'h0, "rd10");
    check("rd10_const", ifa.mem_rdata, 32'h0BADF00D);

    drive(0, 1, 1, 4'hF, 32'h10, 32'h12345678);
    tick();
    check("mid_err_set", {31'd0, err_a}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp", {31'd0, ifa.mem_resp}, 32'd0);
    check("mid_rst_rdata", ifa.mem_rdata, 32'h0);
    check("mid_rst_err", {31'd0, err_a}, 32'd0);
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_err[0]   = 1'b0; exp_err[1] = 1'b0;
    repeat (4) begin
      tick();
      check("post_rst_resp", {31'd0, ifa.mem_resp}, 32'd0);
    end
    do_op(0, 1, 0, 32'h10, 32'h0, 4'h0, "rd10_after_rst");
    check("rd10_old", ifa.mem_rdata, 32'h0BADF00D);

    // ---- basic write/read and rdata hold --------------------------------
    do_op(0, 0, 1, 32'h40, 32'hDEADBEEF, 4'hF, "wr40");
    do_op(0, 1, 0, 32'h40, 32'h0, 4'h0, "rd40");
    check("rd40_const", ifa.mem_rdata, 32'hDEADBEEF);
    do_op(0, 0, 1, 32'h44, 32'h01020304, 4'hF, "wr44_hold");
    check("rd40_held", ifa.mem_rdata, 32'hDEADBEEF);

    // ---- byte masks -----------------------------------------------------
    do_op(0, 0, 1, 32'h80, 32'h11223344, 4'hF, "m_full");
    do_op(0, 0, 1, 32'h80, 32'h000000AA, 4'h1, "m_sb");
    do_op(0, 0, 1, 32'h80, 32'h0000BBCC, 4'h3, "m_sh");
    do_op(0, 1, 0, 32'h80, 32'h0, 4'h0, "m_rd1");
    check("m_rd1_const", ifa.mem_rdata, 32'h1122BBCC);
    do_op(0, 0, 1, 32'h80, 32'h00EE0000, 4'h4, "m_b2");
    do_op(0, 0, 1, 32'h80, 32'hFFFFFFFF, 4'h0, "m_none");
    do_op(0, 1, 0, 32'h83, 32'h0, 4'h0, "m_rd2");
    check("m_rd2_const", ifa.mem_rdata, 32'h11EEBBCC);

    // ---- abort after one wait cycle ------------------------------------
    drive(0, 1, 0, 4'h0, 32'h20, 32'h0);
    tick();
    tick();
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
    n = 0;
    repeat (5) begin
      tick();
      if (ifa.mem_resp) n++;
    end
    check("abort_no_resp", n, 0);
    check("abort_rdata", ifa.mem_rdata, 32'h11EEBBCC);
    do_op(0, 1, 0, 32'h40, 32'h0, 4'h0, "after_abort");

    // ---- randomized mix on dut_a ----------------------------------------
    for (int i = 0; i < 16; i++) begin
      rand_addr[i] = {$urandom_range(0, 1048575), 10'($urandom_range(256, 1023)), 2'($urandom)};
      do_op(0, 0, 1, rand_addr[i], $urandom, 4'hF, "rnd_seed");
    end
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 0)
        do_op(0, 1, 0, rand_addr[k] ^ 32'hFFF0_0003, 32'h0, 4'h0, "rnd_rd");
      else
        do_op(0, 0, 1, rand_addr[k], $urandom, 4'($urandom), "rnd_wr");
    end

    // ---- conflict and wrap ---------------------------------------------
    do_op(0, 1, 1, 32'h1004, 32'hCAFEF00D, 4'hF, "conflict");
    check("conflict_err", {31'd0, err_a}, 32'd1);
    do_op(0, 1, 0, 32'h0004, 32'h0, 4'h0, "wrap_rd");
    check("wrap_const", ifa.mem_rdata, 32'hCAFEF00D);
    check("err_sticky", {31'd0, err_a}, 32'd1);

    // ---- LATENCY=0: seeding, then back-to-back held reads ---------------
    for (int i = 0; i < 8; i++) begin
      fetch_addr[i] = 32'h200 + 32'(i * 4);
      do_op(1, 0, 1, fetch_addr[i], $urandom, 4'hF, "b_seed");
    end
    do_op(1, 1, 0, fetch_addr[3], 32'h0, 4'h0, "b_single");
    drive(1, 1, 0, 4'h0, fetch_addr[7], 32'h0);
    for (int i = 0; i < 8; i++) begin
      int idx;
      idx = 7 - i;
      n = 0;
      do begin
        tick();
        n++;
      end while (!ifb.mem_resp && n < 50);
      check("b2b_lat", n, (i == 0) ? 1 : 3);
      exp_rdata[1] = model_mem[1][word_of(fetch_addr[idx])];
      check("b2b_rdata", ifb.mem_rdata, exp_rdata[1]);
      if (i < 7) drive(1, 1, 0, 4'h0, fetch_addr[idx - 1], 32'h0);
      else       drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
    end
    repeat (3) tick();
    check("b_err_clear", {31'd0, err_b}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
